// File: rtl/cnet_reg_master.sv
// cnet_reg_master: CPCI-side master for the CNET register bus.
// Takes one register read or write at a time from the PCI target logic and
// runs it on the CNET bus. It follows the wr_rdy/rd_rdy flow control,
// captures read data and reports completion or timeout.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | no transaction; waiting for p2n_req
// S_WAIT_RDY | request latched; waiting for the rdy matching the direction
// S_ISSUE    | one-cycle cpci_req strobe; write data driven on cpci_data
// S_RD_WAIT  | read strobed; waiting for cpci_rd_rdy to return the data
// S_TURN     | one idle cycle so the CNET can release cpci_data
// S_DONE     | one-cycle p2n_done pulse; a new request may be accepted here
module cnet_reg_master #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p2n_req,
  input  logic                  p2n_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] p2n_addr,
  input  logic [DATA_WIDTH-1:0] p2n_wr_data,
  output logic                  p2n_busy,
  output logic                  p2n_done,
  output logic                  p2n_err,
  output logic [DATA_WIDTH-1:0] p2n_rd_data,
  output logic                  cpci_req,
  output logic                  cpci_rd_wr_L,
  output logic [ADDR_WIDTH-1:0] cpci_addr,
  inout  wire  [DATA_WIDTH-1:0] cpci_data,
  input  logic                  cpci_wr_rdy,
  input  logic                  cpci_rd_rdy
);

  localparam int CW = $clog2(TIMEOUT);
  // The counter is compared one short of TIMEOUT-1 so that the cycle in
  // which it would reach TIMEOUT-1 is already spent in S_DONE.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_TO   = CW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUE,
    S_RD_WAIT,
    S_TURN,
    S_DONE
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_inc;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  drv_en;
  logic                  rdy_match;
  logic                  accept;

  // Saturating increment of the wait counter, rdy select by direction, and
  // request acceptance (busy is low only in S_IDLE and S_DONE).
  always_comb begin
    cnt_inc   = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;
    rdy_match = cpci_rd_wr_L ? cpci_rd_rdy : cpci_wr_rdy;
    accept    = p2n_req && !p2n_busy;
  end

  // Only the write strobe cycle drives the shared bus.
  assign cpci_data = drv_en ? wr_data_q : {DATA_WIDTH{1'bz}};

  // Sequencing FSM with registered bus and PCI-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      wr_data_q    <= '0;
      drv_en       <= 1'b0;
      p2n_busy     <= 1'b0;
      p2n_done     <= 1'b0;
      p2n_err      <= 1'b0;
      p2n_rd_data  <= '0;
      cpci_req     <= 1'b0;
      cpci_rd_wr_L <= 1'b1;
      cpci_addr    <= '0;
    end else begin
      cpci_req <= 1'b0;
      p2n_done <= 1'b0;
      p2n_err  <= 1'b0;
      drv_en   <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          // Direction and address go straight to the bus registers; they
          // then hold their value while idle.
          if (accept) begin
            state        <= S_WAIT_RDY;
            p2n_busy     <= 1'b1;
            cpci_rd_wr_L <= p2n_rd_wr_L;
            cpci_addr    <= p2n_addr;
            wr_data_q    <= p2n_wr_data;
            cnt          <= '0;
          end else begin
            state <= S_IDLE;
          end
        end

        S_WAIT_RDY: begin
          if (rdy_match) begin
            state    <= S_ISSUE;
            cpci_req <= 1'b1;
            drv_en   <= !cpci_rd_wr_L;
          end else if (cnt == CNT_TO) begin
            state    <= S_DONE;
            p2n_done <= 1'b1;
            p2n_err  <= 1'b1;
            p2n_busy <= 1'b0;
            cnt      <= CNT_LAST;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_ISSUE: begin
          // rdy is deliberately not looked at here: a level left high from
          // the request phase must not be mistaken for read completion.
          if (cpci_rd_wr_L) begin
            state <= S_RD_WAIT;
            cnt   <= '0;
          end else begin
            state    <= S_DONE;
            p2n_done <= 1'b1;
            p2n_busy <= 1'b0;
          end
        end

        S_RD_WAIT: begin
          if (cpci_rd_rdy) begin
            state       <= S_TURN;
            p2n_rd_data <= cpci_data;
          end else if (cnt == CNT_TO) begin
            state    <= S_DONE;
            p2n_done <= 1'b1;
            p2n_err  <= 1'b1;
            p2n_busy <= 1'b0;
            cnt      <= CNT_LAST;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_TURN: begin
          state    <= S_DONE;
          p2n_done <= 1'b1;
          p2n_busy <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          p2n_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
